// File: rtl/home_ctrl_pkg.sv
// Shared appliance-mode encodings, mode LED patterns and mode-switch FSM states.
package home_ctrl_pkg;

  typedef enum logic [1:0] {
    ACTIVE   = 2'd0,
    REL_WAIT = 2'd1,
    GUARD    = 2'd2
  } state_e;

  localparam logic [1:0] MODE_MINSEC    = 2'd0;
  localparam logic [1:0] MODE_MICROWAVE = 2'd1;
  localparam logic [1:0] MODE_AIRCON    = 2'd2;

  localparam logic [2:0] LED_MINSEC    = 3'b100;
  localparam logic [2:0] LED_MICROWAVE = 3'b010;
  localparam logic [2:0] LED_AIRCON    = 3'b001;

  // The unused encoding 3 is treated as stopwatch everywhere.
  function automatic logic [1:0] mode_sanitize(input logic [1:0] m);
    return (m == 2'd3) ? MODE_MINSEC : m;
  endfunction

  function automatic logic [2:0] mode_led_of(input logic [1:0] m);
    case (m)
      MODE_MICROWAVE: return LED_MICROWAVE;
      MODE_AIRCON:    return LED_AIRCON;
      default:        return LED_MINSEC;
    endcase
  endfunction

  function automatic logic [2:0] mode_onehot(input logic [1:0] m);
    return 3'b001 << mode_sanitize(m);
  endfunction

endpackage

// File: rtl/mode_switch_ctrl_cycle_timer.sv
// Free-running cycle counter with synchronous clear and a terminal-count pulse;
// the count wraps to zero on terminal count.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  assign tc_o = en_i && (cnt_q == term_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mode_switch_ctrl.sv
// Appliance mode sequencer: release handshake, blanked guard interval, then grant.
// Optional background-alert beeper is compiled in when BG_ALERT_EN is defined.
module mode_switch_ctrl
  import home_ctrl_pkg::*;
#(
  parameter int N_MODES      = 3,
  parameter int GUARD_CYCLES = 100000,
  parameter int ACK_TIMEOUT  = 10000000,
  parameter int BEEP_HALF    = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       next_req,
  input  logic [2:0] rel_ack,
  output logic [1:0] mode,
  output logic       mode_valid,
  output logic [2:0] rel_req,
  output logic       out_blank,
  output logic [2:0] mode_led,
  output logic       timeout_flag,
  output logic       busy
`ifdef BG_ALERT_EN
  ,
  input  logic [2:0] alert_req,
  output logic       alert_buzz,
  output logic [2:0] alert_pend
`endif
);

  localparam int CNT_MAX = (ACK_TIMEOUT > GUARD_CYCLES) ? ACK_TIMEOUT : GUARD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [1:0]       LAST_MODE  = 2'(N_MODES - 1);

  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d, mode_cur, mode_nxt;
  logic       timeout_flag_q, timeout_flag_d;
  logic       mode_valid_q, mode_valid_d;
  logic [2:0] rel_req_q, rel_req_d;
  logic       out_blank_q, out_blank_d;
  logic [2:0] mode_led_q, mode_led_d;
  logic       busy_q, busy_d;
  logic       tmr_tc, tmr_clr, tmr_en;
  logic [CNT_W-1:0] tmr_term;

  assign mode_cur = mode_sanitize(mode_q);
  assign mode_nxt = (mode_cur == LAST_MODE) ? MODE_MINSEC : mode_cur + 2'd1;

  // One counter serves both the ack timeout and the guard interval; it restarts on every state entry.
  assign tmr_en   = (state_q != ACTIVE);
  assign tmr_clr  = (state_d != state_q);
  assign tmr_term = (state_q == REL_WAIT) ? ACK_LAST : GUARD_LAST;

  cycle_timer #(.W(CNT_W)) u_switch_timer (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_i (tmr_term),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    timeout_flag_d = timeout_flag_q;
    case (state_q)
      ACTIVE: begin
        if (next_req) state_d = REL_WAIT;
      end
      REL_WAIT: begin
        if (rel_ack[mode_cur]) begin
          state_d        = GUARD;
          mode_d         = mode_nxt;
          timeout_flag_d = 1'b0;
        end else if (tmr_tc) begin
          state_d        = GUARD;
          mode_d         = mode_nxt;
          timeout_flag_d = 1'b1;
        end
      end
      GUARD: begin
        if (tmr_tc) state_d = ACTIVE;
      end
      default: begin
        state_d = ACTIVE;
        mode_d  = MODE_MINSEC;
      end
    endcase
    rel_req_d    = (state_d == REL_WAIT) ? mode_onehot(mode_d) : 3'b000;
    out_blank_d  = (state_d == GUARD);
    mode_valid_d = (state_d != GUARD);
    busy_d       = (state_d != ACTIVE);
    mode_led_d   = mode_led_of(mode_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ACTIVE;
      mode_q         <= MODE_MINSEC;
      timeout_flag_q <= 1'b0;
      mode_valid_q   <= 1'b1;
      rel_req_q      <= 3'b000;
      out_blank_q    <= 1'b0;
      mode_led_q     <= LED_MINSEC;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      timeout_flag_q <= timeout_flag_d;
      mode_valid_q   <= mode_valid_d;
      rel_req_q      <= rel_req_d;
      out_blank_q    <= out_blank_d;
      mode_led_q     <= mode_led_d;
      busy_q         <= busy_d;
    end
  end

  assign mode         = mode_q;
  assign mode_valid   = mode_valid_q;
  assign rel_req      = rel_req_q;
  assign out_blank    = out_blank_q;
  assign mode_led     = mode_led_q;
  assign timeout_flag = timeout_flag_q;
  assign busy         = busy_q;

`ifdef BG_ALERT_EN
  localparam int BEEP_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF - 1);

  logic [2:0] alert_req_q, alert_pend_q, alert_pend_d;
  logic       beep_on_q, beep_on_d, buzz_q, buzz_d, beep_tc;

  cycle_timer #(.W(BEEP_W)) u_beep_timer (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (~beep_on_q),
    .en_i   (beep_on_q),
    .term_i (BEEP_LAST),
    .tc_o   (beep_tc)
  );

  // A pending alert for the mode being entered is dropped on the same edge that grants it.
  always_comb begin
    alert_pend_d = (alert_pend_q | (alert_req & ~alert_req_q & ~mode_onehot(mode_cur)))
                   & ~mode_onehot(mode_d);
    beep_on_d    = (state_d == ACTIVE) && (|alert_pend_d);
    buzz_d       = 1'b0;
    if (beep_on_d) buzz_d = beep_on_q ? (buzz_q ^ beep_tc) : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alert_req_q  <= 3'b000;
      alert_pend_q <= 3'b000;
      beep_on_q    <= 1'b0;
      buzz_q       <= 1'b0;
    end else begin
      alert_req_q  <= alert_req;
      alert_pend_q <= alert_pend_d;
      beep_on_q    <= beep_on_d;
      buzz_q       <= buzz_d;
    end
  end

  assign alert_buzz = buzz_q;
  assign alert_pend = alert_pend_q;
`endif

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Self-checking bench for mode_switch_ctrl: timeline-based reference model plus pinned cycle checks.
module tb_mode_switch_ctrl;

  localparam int G = 4;
  localparam int A = 8;
  localparam int B = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       next_req;
  logic [2:0] rel_ack;
  logic [1:0] mode;
  logic       mode_valid;
  logic [2:0] rel_req;
  logic       out_blank;
  logic [2:0] mode_led;
  logic       timeout_flag;
  logic       busy;
`ifdef BG_ALERT_EN
  logic [2:0] alert_req;
  logic       alert_buzz;
  logic [2:0] alert_pend;
`endif

  mode_switch_ctrl #(
    .N_MODES(3), .GUARD_CYCLES(G), .ACK_TIMEOUT(A), .BEEP_HALF(B)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .next_req     (next_req),
    .rel_ack      (rel_ack),
    .mode         (mode),
    .mode_valid   (mode_valid),
    .rel_req      (rel_req),
    .out_blank    (out_blank),
    .mode_led     (mode_led),
    .timeout_flag (timeout_flag),
    .busy         (busy)
`ifdef BG_ALERT_EN
    ,
    .alert_req    (alert_req),
    .alert_buzz   (alert_buzz),
    .alert_pend   (alert_pend)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: a switch is a timeline (release window start, guard start) rather than states.
  int m_n = 0;
  bit m_ready = 0;
  bit m_sw;
  int m_rel_start, m_guard_start;
  int m_mode, m_old;
  bit m_flag;
  bit [2:0] m_prev, m_pend, m_rise;
  bit m_beep_prev, m_cond, m_buzz;
  int m_beep_start;

  always @(posedge clk) begin
    m_n = m_n + 1;
    if (reset) begin
      m_ready = 1; m_sw = 0; m_guard_start = -1; m_mode = 0; m_flag = 0;
      m_prev = 0; m_pend = 0; m_beep_prev = 0; m_buzz = 0;
    end else if (m_ready) begin
      m_old = m_mode;
      if (!m_sw) begin
        if (next_req) begin m_sw = 1; m_rel_start = m_n; m_guard_start = -1; end
      end else if (m_guard_start < 0) begin
        if (rel_ack[m_mode]) begin
          m_guard_start = m_n; m_flag = 0; m_mode = (m_mode + 1) % 3;
        end else if (m_n - m_rel_start == A) begin
          m_guard_start = m_n; m_flag = 1; m_mode = (m_mode + 1) % 3;
        end
      end else if (m_n - m_guard_start == G) begin
        m_sw = 0;
      end
`ifdef BG_ALERT_EN
      m_rise = alert_req & ~m_prev;
      m_prev = alert_req;
      m_pend = m_pend | (m_rise & ~(3'b001 << m_old));
      m_pend = m_pend & ~(3'b001 << m_mode);
      m_cond = !m_sw && (m_pend != 0);
      if (m_cond && !m_beep_prev) m_beep_start = m_n;
      m_beep_prev = m_cond;
      m_buzz = m_cond && ((((m_n - m_beep_start) / B) % 2) == 0);
`endif
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("mode", int'(mode), m_mode);
      chk("rel_req", int'(rel_req), (m_sw && m_guard_start < 0) ? (1 << m_mode) : 0);
      chk("out_blank", int'(out_blank), int'(m_sw && m_guard_start >= 0));
      chk("mode_valid", int'(mode_valid), int'(!(m_sw && m_guard_start >= 0)));
      chk("busy", int'(busy), int'(m_sw));
      chk("mode_led", int'(mode_led), 4 >> m_mode);
      chk("timeout_flag", int'(timeout_flag), int'(m_flag));
`ifdef BG_ALERT_EN
      chk("alert_pend", int'(alert_pend), int'(m_pend));
      chk("alert_buzz", int'(alert_buzz), int'(m_buzz));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_switch();
    next_req = 1; step(); next_req = 0; step();
    rel_ack = 3'(1 << m_mode); step(); rel_ack = 0;
    repeat (8) step();
  endtask

  initial begin
    reset = 1; next_req = 0; rel_ack = 0;
`ifdef BG_ALERT_EN
    alert_req = 0;
`endif
    repeat (3) step();
    reset = 0;
    chk("reset_mode_led", int'(mode_led), 3'b100);
    chk("reset_valid", int'(mode_valid), 1);

    // 1: pinned latency of one handshaked switch
    while (cyc < 10) step();
    next_req = 1; step(); next_req = 0;
    chk("t1_rel_req_c11", int'(rel_req), 3'b001);
    chk("t1_busy_c11", int'(busy), 1);
    step(); chk("t1_rel_req_c12", int'(rel_req), 3'b001);
    step(); chk("t1_rel_req_c13", int'(rel_req), 3'b001);
    rel_ack = 3'b001;
    step(); rel_ack = 0;
    chk("t1_mode_c14", int'(mode), 1);
    chk("t1_blank_c14", int'(out_blank), 1);
    repeat (3) step(); chk("t1_valid_c17", int'(mode_valid), 0);
    step();
    chk("t1_valid_c18", int'(mode_valid), 1);
    chk("t1_led_c18", int'(mode_led), 3'b010);

    // 2: complete the 0->1->2->0 cycle
    do_switch(); chk("t2_led_mw_to_ac", int'(mode_led), 3'b001);
    do_switch();
    chk("t2_mode_wrap", int'(mode), 0);
    chk("t2_flag", int'(timeout_flag), 0);

    // 3: forced switch on missing ack, cleared by the next handshaked one
    next_req = 1; step(); next_req = 0;
    repeat (20) step();
    chk("t3_flag_set", int'(timeout_flag), 1);
    chk("t3_mode", int'(mode), 1);
    do_switch();
    chk("t3_flag_clr", int'(timeout_flag), 0);

    // 4: ignored requests and foreign acks
    reset = 1; step(); reset = 0; step();
    next_req = 1; step(); next_req = 0;
    rel_ack = 3'b100; step(); rel_ack = 0;
    chk("t4_foreign_ack", int'(rel_req), 3'b001);
    next_req = 1; step(); next_req = 0;
    rel_ack = 3'b001; step(); rel_ack = 0;
    step(); next_req = 1; step(); next_req = 0;
    repeat (10) step();
    chk("t4_one_advance", int'(mode), 1);
    chk("t4_idle", int'(busy), 0);

    // 5: reset during the guard into mode 2
    next_req = 1; step(); next_req = 0;
    rel_ack = 3'b010; step(); rel_ack = 0; step();
    chk("t5_guard_mode", int'(mode), 2);
    chk("t5_guard_blank", int'(out_blank), 1);
    reset = 1; step(); reset = 0;
    chk("t5_mode", int'(mode), 0);
    chk("t5_blank", int'(out_blank), 0);
    chk("t5_valid", int'(mode_valid), 1);
    chk("t5_rel_req", int'(rel_req), 0);
    chk("t5_busy", int'(busy), 0);

`ifdef BG_ALERT_EN
    // 6: background alert from microwave while stopwatch is shown
    alert_req = 3'b010; step();
    chk("t6_pend", int'(alert_pend), 3'b010);
    chk("t6_buzz_hi", int'(alert_buzz), 1);
    repeat (3) step();
    chk("t6_buzz_lo", int'(alert_buzz), 0);
    alert_req = 0;
    next_req = 1; step(); next_req = 0; step();
    rel_ack = 3'b001; step(); rel_ack = 0;
    chk("t6_pend_clr", int'(alert_pend), 0);
    chk("t6_buzz_off", int'(alert_buzz), 0);
    repeat (8) step();
`endif

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      next_req = ($urandom_range(0, 5) == 0);
      rel_ack  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
`ifdef BG_ALERT_EN
      if ($urandom_range(0, 7) == 0) alert_req = 3'($urandom_range(0, 7));
`endif
      step();
    end
    reset = 0; next_req = 0; rel_ack = 0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
